axi_lite_regfile: RTL and testbench



---
 rtl/axi_lite_regfile_if.sv | 37 +++
 rtl/axi_lite_regfile.sv | 164 ++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle for axi_lite_regfile; slave modport faces the register file.
interface axi_lite_regfile_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_wvalid;
  logic                    axi_wready;
  logic [1:0]              axi_bresp;
  logic                    axi_bvalid;
  logic                    axi_bready;
  logic [ADDR_WIDTH-1:0]   axi_araddr;
  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]              axi_rresp;
  logic                    axi_rvalid;
  logic                    axi_rready;

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI4-Lite register file with byte strobes and per-register write pulses.
// Define AXI_LITE_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_regfile #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite_regfile_if.slave              axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFS_W;

  logic                  r_ready_en;
  logic                  r_aw_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pulse;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [NUM_REGS-1:0]   w_wr_sel;
  logic                  w_wr_in_range;
  logic [IDX_W-1:0]      w_ar_idx;
  logic [NUM_REGS-1:0]   w_rd_sel;
  logic                  w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [1:0]            w_bresp_nxt;
  logic [1:0]            w_rresp_nxt;
  logic                  w_unused_ofs;

  // Byte-offset bits never take part in decode.
  assign w_unused_ofs = ^{axi.axi_awaddr[OFS_W-1:0], axi.axi_araddr[OFS_W-1:0]};

  assign axi.axi_awready = r_ready_en && !r_aw_held && !r_bvalid;
  assign axi.axi_wready  = r_ready_en && !r_w_held  && !r_bvalid;
  assign axi.axi_arready = r_ready_en && !r_rvalid;
  assign axi.axi_bvalid  = r_bvalid;
  assign axi.axi_bresp   = r_bresp;
  assign axi.axi_rvalid  = r_rvalid;
  assign axi.axi_rdata   = r_rdata;
  assign axi.axi_rresp   = r_rresp;
  assign reg_wr_pulse    = r_pulse;

  assign w_aw_hs  = axi.axi_awvalid && axi.axi_awready;
  assign w_w_hs   = axi.axi_wvalid  && axi.axi_wready;
  assign w_ar_hs  = axi.axi_arvalid && axi.axi_arready;
  // Commit as soon as both halves are present, whether held from earlier or handshaking now.
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_wr_idx  = r_aw_held ? r_aw_idx : axi.axi_awaddr[ADDR_WIDTH-1:OFS_W];
  assign w_wr_data = r_w_held  ? r_wdata  : axi.axi_wdata;
  assign w_wr_strb = r_w_held  ? r_wstrb  : axi.axi_wstrb;
  assign w_ar_idx  = axi.axi_araddr[ADDR_WIDTH-1:OFS_W];

  always_comb begin
    w_wr_sel  = '0;
    w_rd_sel  = '0;
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(w_wr_idx) == i) w_wr_sel[i] = 1'b1;
      if (32'(w_ar_idx) == i) begin
        w_rd_sel[i] = 1'b1;
        w_rd_data   = r_regs[i];
      end
    end
  end

  assign w_wr_in_range = |w_wr_sel;
  assign w_rd_in_range = |w_rd_sel;

`ifdef AXI_LITE_REGFILE_SLVERR_EN
  assign w_bresp_nxt = w_wr_in_range ? 2'b00 : 2'b10;
  assign w_rresp_nxt = w_rd_in_range ? 2'b00 : 2'b10;
`else
  assign w_bresp_nxt = 2'b00;
  assign w_rresp_nxt = 2'b00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_aw_idx   <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_pulse    <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_pulse    <= '0;
      if (r_bvalid && axi.axi_bready) r_bvalid <= 1'b0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_bresp_nxt;
        r_pulse   <= w_wr_sel;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= axi.axi_awaddr[ADDR_WIDTH-1:OFS_W];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= axi.axi_wdata;
          r_wstrb  <= axi.axi_wstrb;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else if (w_commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (w_wr_sel[i] && w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read samples r_regs before any same-edge commit lands, so it sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rresp_nxt;
    end else if (r_rvalid && axi.axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed plus randomized bench for axi_lite_regfile against an array-based register model.
module tb_axi_lite_regfile;
  localparam int          AW = 12;
  localparam int          DW = 32;
  localparam int          NR = 8;
  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic clk;
  logic rst;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wr_pulse;

  axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RESET_VALUE(RV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axi         (bus.slave),
    .reg_q       (reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [NR];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_q();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
    return v;
  endfunction

  function automatic logic [1:0] oor_resp();
`ifdef AXI_LITE_REGFILE_SLVERR_EN
    return 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = RV;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lag, input int w_lag, input int bhold);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_now, w_now;
    int cyc = 0;
    int idx;
    logic [NR-1:0] exp_pulse;
    logic [1:0]    exp_resp;
    bus.axi_awaddr = addr;
    bus.axi_wdata  = data;
    bus.axi_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.axi_awvalid = !aw_done && (cyc >= aw_lag);
      bus.axi_wvalid  = !w_done && (cyc >= w_lag);
      aw_now = bus.axi_awvalid && bus.axi_awready;
      w_now  = bus.axi_wvalid && bus.axi_wready;
      @(posedge clk); #1;
      aw_done |= aw_now;
      w_done  |= w_now;
      cyc++;
      if (!(aw_done && w_done)) chk("bvalid_before_commit", bus.axi_bvalid, 1'b0);
    end
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    chk("wr_handshake_in_time", aw_done && w_done, 1'b1);
    idx = int'(addr) / 4;
    exp_pulse = '0;
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_pulse[idx] = 1'b1;
      exp_resp = 2'b00;
    end else begin
      exp_resp = oor_resp();
    end
    chk("bvalid_after_commit", bus.axi_bvalid, 1'b1);
    chk("bresp", bus.axi_bresp, exp_resp);
    chk("wr_pulse", reg_wr_pulse, exp_pulse);
    chk("reg_q_after_write", reg_q, model_q());
    for (int k = 0; k < bhold; k++) begin
      @(posedge clk); #1;
      chk("bvalid_held", bus.axi_bvalid, 1'b1);
      chk("awready_blocked", bus.axi_awready, 1'b0);
      chk("wready_blocked", bus.axi_wready, 1'b0);
      chk("wr_pulse_single", reg_wr_pulse, '0);
    end
    bus.axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_bready = 1'b0;
    chk("bvalid_cleared", bus.axi_bvalid, 1'b0);
    chk("awready_back", bus.axi_awready, 1'b1);
    chk("wready_back", bus.axi_wready, 1'b1);
    chk("wr_pulse_gone", reg_wr_pulse, '0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int rhold);
    bit done = 0;
    bit now;
    int cyc = 0;
    int idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    idx = int'(addr) / 4;
    exp_data = (idx < NR) ? mdl[idx] : 32'h0;
    exp_resp = (idx < NR) ? 2'b00 : oor_resp();
    bus.axi_araddr = addr;
    while (!done && cyc < 40) begin
      bus.axi_arvalid = 1'b1;
      now = bus.axi_arready;
      @(posedge clk); #1;
      done = now;
      cyc++;
    end
    bus.axi_arvalid = 1'b0;
    chk("rd_handshake_in_time", done, 1'b1);
    chk("rvalid", bus.axi_rvalid, 1'b1);
    chk("rdata", bus.axi_rdata, exp_data);
    chk("rresp", bus.axi_rresp, exp_resp);
    for (int k = 0; k < rhold; k++) begin
      @(posedge clk); #1;
      chk("rvalid_held", bus.axi_rvalid, 1'b1);
      chk("arready_blocked", bus.axi_arready, 1'b0);
      chk("rdata_stable", bus.axi_rdata, exp_data);
    end
    bus.axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.axi_rready = 1'b0;
    chk("rvalid_cleared", bus.axi_rvalid, 1'b0);
    chk("arready_back", bus.axi_arready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    logic [AW-1:0] a;
    bus.axi_awaddr = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_araddr = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;
    rst = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_q", reg_q, model_q());
    chk("rst_awready", bus.axi_awready, 1'b0);
    chk("rst_wready", bus.axi_wready, 1'b0);
    chk("rst_arready", bus.axi_arready, 1'b0);
    chk("rst_bvalid", bus.axi_bvalid, 1'b0);
    chk("rst_rvalid", bus.axi_rvalid, 1'b0);
    chk("rst_bresp", bus.axi_bresp, 2'b00);
    chk("rst_rresp", bus.axi_rresp, 2'b00);
    chk("rst_rdata", bus.axi_rdata, 32'h0);
    chk("rst_pulse", reg_wr_pulse, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_awready", bus.axi_awready, 1'b1);
    chk("post_rst_wready", bus.axi_wready, 1'b1);
    chk("post_rst_arready", bus.axi_arready, 1'b1);

    // AW first, W three cycles later, partial strobe
    axi_write(12'h004, 32'hDEADBEEF, 4'b0011, 0, 3, 0);
    chk("reg1_partial", reg_q[63:32], 32'hA5A5_BEEF);
    // W first, then AW; zero strobe still pulses
    axi_write(12'h00C, 32'h11112222, 4'b0000, 2, 0, 0);
    chk("reg3_untouched", reg_q[127:96], RV);
    // bready held low for 5 cycles
    axi_write(12'h014, 32'hCAFEF00D, 4'b1111, 0, 0, 5);
    axi_read(12'h004, 0);
    axi_read(12'h017, 3);

    // Simultaneous write and read of the same register
    old = mdl[2];
    chk("idle_awready", bus.axi_awready, 1'b1);
    chk("idle_arready", bus.axi_arready, 1'b1);
    bus.axi_awaddr = 12'h008; bus.axi_awvalid = 1'b1;
    bus.axi_wdata = 32'h12345678; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
    bus.axi_araddr = 12'h008; bus.axi_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
    mdl[2] = 32'h12345678;
    chk("same_cycle_rvalid", bus.axi_rvalid, 1'b1);
    chk("same_cycle_bvalid", bus.axi_bvalid, 1'b1);
    chk("same_cycle_rdata_old", bus.axi_rdata, old);
    chk("same_cycle_reg_q", reg_q, model_q());
    bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;
    chk("same_cycle_bclear", bus.axi_bvalid, 1'b0);
    chk("same_cycle_rclear", bus.axi_rvalid, 1'b0);
    axi_read(12'h008, 0);

    // Out of range
    axi_write(12'h040, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_read(12'h040, 1);
    axi_write(12'hFFC, 32'h0BADF00D, 4'hF, 1, 0, 0);

    // Reset while AW is held and W is not
    bus.axi_awaddr = 12'h00C; bus.axi_awvalid = 1'b1;
    chk("hold_aw_ready", bus.axi_awready, 1'b1);
    @(posedge clk); #1;
    bus.axi_awvalid = 1'b0;
    chk("aw_held_blocks", bus.axi_awready, 1'b0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_bvalid", bus.axi_bvalid, 1'b0);
    chk("rst_mid_reg_q", reg_q, model_q());
    chk("rst_mid_awready", bus.axi_awready, 1'b1);
    axi_write(12'h010, 32'h55667788, 4'hF, 3, 0, 0);
    chk("rst_mid_target_reg4", reg_q[159:128], 32'h55667788);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      a = 12'($urandom_range(0, 47));
      if ($urandom_range(0, 2) == 2) axi_read(a, $urandom_range(0, 2));
      else axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    for (int i = 0; i < NR; i++) axi_read(12'(i * 4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
